digital_clock_bcd: RTL and testbench
====================================

Name: digital_clock_bcd

Overview:
- Parametrised successor of the binary seconds/minutes/hours counter.
- Runs from the system clock with an internal prescaler instead of an external 1 Hz clock.
- Adds run/pause, time-set load with range check, a 12/24-hour display mode, and a latched alarm.
- Drives six packed BCD digits that feed the 7-segment multiplexer directly.

Parameters:
- TICKS_PER_SEC, 100000000: clk cycles per second. Must be ≥2. Prescaler width is $clog2(TICKS_PER_SEC).

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high
- run  in  1  1 = time advances; 0 = prescaler and time hold
- mode_12h  in  1  1 = 12-hour display, 0 = 24-hour display
- set_valid  in  1  load request, sampled each cycle
- set_hours  in  5  binary hours 0..23
- set_minutes  in  6  binary minutes 0..59
- set_seconds  in  6  binary seconds 0..59
- alarm_en  in  1  alarm compare enable
- alarm_hours  in  5  binary, 24-hour format
- alarm_minutes  in  6  binary
- alarm_ack  in  1  clears alarm
- bcd_time  out  24  {h_tens,h_ones,m_tens,m_ones,s_tens,s_ones}, 4 bits each
- pm  out  1  high when internal hours ≥12, valid in both modes
- sec_tick  out  1  one-cycle pulse when time advanced
- set_err  out  1  one-cycle pulse when a set request was rejected
- alarm  out  1  latched alarm flag

Behaviour:
- All state updates occur on the rising edge of clk.
- Reset has top priority. It clears the prescaler, time (00:00:00), sec_tick, set_err and alarm.
- After reset: bcd_time = 0x000000 in 24h mode, or 0x120000 when mode_12h=1 (combinational display). pm = 0.
- Internal state is binary hours (0..23), minutes and seconds. bcd_time and pm decode combinationally from these registers: zero latency and no extra register.
- Prescaler:
  - While run=1 it counts 0..TICKS_PER_SEC-1.
  - On the edge where it equals TICKS_PER_SEC-1, it wraps to 0 and time advances one second.
  - sec_tick is a registered pulse, high exactly the cycle after the advance, coincident with the new time value.
  - With run=0, prescaler and time hold and no tick occurs.
- Advance:
  - seconds 59 → 0 with minutes +1.
  - minutes 59 → 0 with hours +1.
  - hours 23 → 0.
  - Counters never take values ≥60 (min/sec) or ≥24 (hours), even transiently.
- 12-hour display:
  - Internal 0 displays as 12.
  - 1..12 display as-is.
  - 13..23 display as h-12.
  - Hour tens digit is 0 or 1. Minutes and seconds are unaffected.
  - mode_12h may change at any time; the display follows immediately. Internal time is never modified by the mode.
- Set:
  - set_valid=1 with all fields in range loads time and clears the prescaler to 0. Counting resumes a full second later. No sec_tick is generated.
  - Any field out of range: the request is ignored, time is unchanged, and set_err pulses the next cycle.
  - Set wins over a coincident prescaler wrap; that second is discarded.
  - Set is accepted regardless of run.
- Alarm:
  - On a tick-driven advance whose result is hh:mm:00 with alarm_en=1, hh == alarm_hours and mm == alarm_minutes, alarm is set to 1. It is visible with sec_tick.
  - A set-load to a matching time does not trigger the alarm.
  - alarm is cleared by alarm_ack=1 or alarm_en=0.
  - If a clear and a trigger occur in the same cycle, the trigger wins.
  - Out-of-range alarm values never match.
- Reset mid-operation discards any pending set, tick or alarm.

Test Plan:
- TICKS_PER_SEC=4, run=1, set 23:59:58. After 8 cycles: bcd_time steps 0x235959 → 0x000000. sec_tick pulses every 4th cycle; pm 1 → 0.
- mode_12h=1, set 00:30:00 → bcd_time 0x123000, pm=0. Set 13:05:09 → 0x010509, pm=1. Set 12:00:00 → 0x120000, pm=1. Toggle mode_12h=0 → 0x130509 on the same cycle (for the 13:05:09 state).
- set_hours=24 or set_minutes=60 → set_err pulses one cycle and bcd_time is unchanged. set_valid asserted on the prescaler-wrap cycle → loaded value shown, no sec_tick, next advance after 4 further cycles.
- alarm_en=1, alarm 07:15, set 07:14:59, run → alarm rises with the sec_tick showing 0x071500. It stays high through later ticks. alarm_ack clears it. Set 07:15:00 directly → no alarm.
- run=0 for 10 cycles → bcd_time and prescaler frozen, no sec_tick. run=1 → tick resumes from the held prescaler value.
- Assert reset mid-count with alarm=1 → next cycle time 00:00:00, alarm=0, sec_tick=0. Prescaler restarts so the first tick follows exactly 4 cycles after reset deasserts.

Source files
------------

// File: rtl/digital_clock_bcd.sv
// digital_clock_bcd: prescaled hh:mm:ss clock with set/range-check, 12/24h BCD display and latched alarm
module digital_clock_bcd #(
    parameter int TICKS_PER_SEC = 100000000
) (
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic        i_run,
    input  logic        i_mode_12h,
    input  logic        i_set_valid,
    input  logic [4:0]  i_set_hours,
    input  logic [5:0]  i_set_minutes,
    input  logic [5:0]  i_set_seconds,
    input  logic        i_alarm_en,
    input  logic [4:0]  i_alarm_hours,
    input  logic [5:0]  i_alarm_minutes,
    input  logic        i_alarm_ack,
    output logic [23:0] o_bcd_time,
    output logic        o_pm,
    output logic        o_sec_tick,
    output logic        o_set_err,
    output logic        o_alarm
);
    localparam int PW = $clog2(TICKS_PER_SEC);
    localparam logic [PW-1:0] LAST = PW'(TICKS_PER_SEC - 1);
    localparam logic [PW-1:0] ONE = PW'(1);

    logic [PW-1:0] r_presc;
    logic [4:0]    r_h;
    logic [5:0]    r_m, r_s;
    logic          r_tick, r_err, r_alarm;
    logic          w_set_ok, w_wrap, w_adv, w_hit, w_s_wrap, w_m_wrap;
    logic [4:0]    w_nh;
    logic [5:0]    w_nm, w_ns, w_hd;

    function automatic logic [7:0] bcd2(input logic [5:0] v);
        logic [3:0] t;
        t = (v >= 6'd50) ? 4'd5 : (v >= 6'd40) ? 4'd4 : (v >= 6'd30) ? 4'd3 :
            (v >= 6'd20) ? 4'd2 : (v >= 6'd10) ? 4'd1 : 4'd0;
        return {t, v[3:0] - t * 4'd10};
    endfunction

    assign w_set_ok = i_set_valid && i_set_hours < 5'd24 && i_set_minutes < 6'd60 && i_set_seconds < 6'd60;
    assign w_wrap   = i_run && r_presc == LAST;
    assign w_adv    = w_wrap && !w_set_ok;
    assign w_s_wrap = r_s == 6'd59;
    assign w_m_wrap = r_m == 6'd59;
    assign w_ns     = w_s_wrap ? 6'd0 : r_s + 6'd1;
    assign w_nm     = w_s_wrap ? (w_m_wrap ? 6'd0 : r_m + 6'd1) : r_m;
    assign w_nh     = (w_s_wrap && w_m_wrap) ? (r_h == 5'd23 ? 5'd0 : r_h + 5'd1) : r_h;
    assign w_hit    = w_adv && i_alarm_en && w_ns == 6'd0 && w_nm == i_alarm_minutes && w_nh == i_alarm_hours;

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_presc <= '0;
            r_h     <= '0;
            r_m     <= '0;
            r_s     <= '0;
            r_tick  <= 1'b0;
            r_err   <= 1'b0;
            r_alarm <= 1'b0;
        end else begin
            r_tick  <= w_adv;
            r_err   <= i_set_valid && !w_set_ok;
            r_alarm <= w_hit ? 1'b1 : (i_alarm_ack || !i_alarm_en) ? 1'b0 : r_alarm;
            if (w_set_ok) begin
                r_presc <= '0;
                r_h     <= i_set_hours;
                r_m     <= i_set_minutes;
                r_s     <= i_set_seconds;
            end else if (i_run) begin
                r_presc <= w_wrap ? '0 : r_presc + ONE;
                if (w_wrap) begin
                    r_h <= w_nh;
                    r_m <= w_nm;
                    r_s <= w_ns;
                end
            end
        end
    end

    assign w_hd = !i_mode_12h ? {1'b0, r_h} :
                  (r_h == 5'd0) ? 6'd12 :
                  (r_h > 5'd12) ? {1'b0, r_h - 5'd12} : {1'b0, r_h};

    assign o_bcd_time = {bcd2(w_hd), bcd2(r_m), bcd2(r_s)};
    assign o_pm       = r_h >= 5'd12;
    assign o_sec_tick = r_tick;
    assign o_set_err  = r_err;
    assign o_alarm    = r_alarm;
endmodule

// File: tb/tb_digital_clock_bcd.sv
// tb_digital_clock_bcd: directed scenario tasks with hand-computed expectations, TICKS_PER_SEC=4
module tb_digital_clock_bcd;
    logic        clk = 1'b0;
    logic        reset = 1'b1, run = 1'b0, mode_12h = 1'b0, set_valid = 1'b0;
    logic [4:0]  set_hours = '0, alarm_hours = '0;
    logic [5:0]  set_minutes = '0, set_seconds = '0, alarm_minutes = '0;
    logic        alarm_en = 1'b0, alarm_ack = 1'b0;
    logic [23:0] bcd_time;
    logic        pm, sec_tick, set_err, alarm;
    int          n_tests = 0, n_fail = 0;

    always #5 clk = ~clk;

    digital_clock_bcd #(.TICKS_PER_SEC(4)) dut (
        .i_clk(clk), .i_reset(reset), .i_run(run), .i_mode_12h(mode_12h),
        .i_set_valid(set_valid), .i_set_hours(set_hours), .i_set_minutes(set_minutes),
        .i_set_seconds(set_seconds), .i_alarm_en(alarm_en), .i_alarm_hours(alarm_hours),
        .i_alarm_minutes(alarm_minutes), .i_alarm_ack(alarm_ack),
        .o_bcd_time(bcd_time), .o_pm(pm), .o_sec_tick(sec_tick), .o_set_err(set_err), .o_alarm(alarm)
    );

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic load(input logic [4:0] h, input logic [5:0] m, input logic [5:0] s);
        set_valid = 1'b1; set_hours = h; set_minutes = m; set_seconds = s;
        cyc();
        set_valid = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        cyc(); cyc();
        reset = 1'b0;
        n_tests++; if (bcd_time !== 24'h000000) begin n_fail++; $display("FAIL reset_bcd24 got=%h exp=000000", bcd_time); end
        n_tests++; if ({pm, sec_tick, set_err, alarm} !== 4'b0) begin n_fail++; $display("FAIL reset_flags got=%b exp=0000", {pm, sec_tick, set_err, alarm}); end
        mode_12h = 1'b1; #1;
        n_tests++; if (bcd_time !== 24'h120000) begin n_fail++; $display("FAIL reset_bcd12 got=%h exp=120000", bcd_time); end
        mode_12h = 1'b0;
    endtask

    task automatic test_rollover();
        run = 1'b1;
        load(5'd23, 6'd59, 6'd58);
        n_tests++; if (bcd_time !== 24'h235958 || pm !== 1'b1 || sec_tick !== 1'b0) begin n_fail++; $display("FAIL roll_load got=%h pm=%b tick=%b exp=235958 1 0", bcd_time, pm, sec_tick); end
        for (int i = 0; i < 8; i++) begin
            cyc();
            n_tests++; if (sec_tick !== (i % 4 == 3)) begin n_fail++; $display("FAIL roll_tick cyc=%0d got=%b exp=%b", i, sec_tick, i % 4 == 3); end
            if (i == 3) begin
                n_tests++; if (bcd_time !== 24'h235959 || pm !== 1'b1) begin n_fail++; $display("FAIL roll_59 got=%h pm=%b exp=235959 1", bcd_time, pm); end
            end
        end
        n_tests++; if (bcd_time !== 24'h000000 || pm !== 1'b0) begin n_fail++; $display("FAIL roll_wrap got=%h pm=%b exp=000000 0", bcd_time, pm); end
        run = 1'b0;
    endtask

    task automatic test_mode_12h();
        mode_12h = 1'b1;
        load(5'd0, 6'd30, 6'd0);
        n_tests++; if (bcd_time !== 24'h123000 || pm !== 1'b0) begin n_fail++; $display("FAIL m12_0030 got=%h pm=%b exp=123000 0", bcd_time, pm); end
        load(5'd13, 6'd5, 6'd9);
        n_tests++; if (bcd_time !== 24'h010509 || pm !== 1'b1) begin n_fail++; $display("FAIL m12_1305 got=%h pm=%b exp=010509 1", bcd_time, pm); end
        mode_12h = 1'b0; #1;
        n_tests++; if (bcd_time !== 24'h130509 || pm !== 1'b1) begin n_fail++; $display("FAIL m24_1305 got=%h pm=%b exp=130509 1", bcd_time, pm); end
        mode_12h = 1'b1;
        load(5'd11, 6'd59, 6'd0);
        n_tests++; if (bcd_time !== 24'h115900 || pm !== 1'b0) begin n_fail++; $display("FAIL m12_1159 got=%h pm=%b exp=115900 0", bcd_time, pm); end
        load(5'd12, 6'd0, 6'd0);
        n_tests++; if (bcd_time !== 24'h120000 || pm !== 1'b1) begin n_fail++; $display("FAIL m12_1200 got=%h pm=%b exp=120000 1", bcd_time, pm); end
        mode_12h = 1'b0;
    endtask

    task automatic test_set();
        logic [16:0] bad [3];
        bad[0] = {5'd24, 6'd0, 6'd0};
        bad[1] = {5'd1, 6'd60, 6'd0};
        bad[2] = {5'd1, 6'd0, 6'd63};
        for (int i = 0; i < 3; i++) begin
            load(bad[i][16:12], bad[i][11:6], bad[i][5:0]);
            n_tests++; if (set_err !== 1'b1 || bcd_time !== 24'h120000) begin n_fail++; $display("FAIL set_bad%0d err=%b bcd=%h exp=1 120000", i, set_err, bcd_time); end
            cyc();
            n_tests++; if (set_err !== 1'b0) begin n_fail++; $display("FAIL set_err_pulse%0d got=%b exp=0", i, set_err); end
        end
        run = 1'b1;
        load(5'd10, 6'd0, 6'd0);
        cyc(); cyc(); cyc();
        load(5'd5, 6'd6, 6'd7);
        n_tests++; if (bcd_time !== 24'h050607 || sec_tick !== 1'b0 || set_err !== 1'b0) begin n_fail++; $display("FAIL set_on_wrap bcd=%h tick=%b err=%b exp=050607 0 0", bcd_time, sec_tick, set_err); end
        for (int i = 0; i < 4; i++) begin
            cyc();
            n_tests++; if (sec_tick !== (i == 3)) begin n_fail++; $display("FAIL set_resume_tick cyc=%0d got=%b exp=%b", i, sec_tick, i == 3); end
        end
        n_tests++; if (bcd_time !== 24'h050608) begin n_fail++; $display("FAIL set_resume_bcd got=%h exp=050608", bcd_time); end
        run = 1'b0;
    endtask

    task automatic test_alarm();
        alarm_en = 1'b1; alarm_hours = 5'd7; alarm_minutes = 6'd15; run = 1'b1;
        load(5'd7, 6'd14, 6'd59);
        cyc(); cyc(); cyc();
        n_tests++; if (alarm !== 1'b0) begin n_fail++; $display("FAIL alarm_early got=%b exp=0", alarm); end
        cyc();
        n_tests++; if (alarm !== 1'b1 || sec_tick !== 1'b1 || bcd_time !== 24'h071500) begin n_fail++; $display("FAIL alarm_rise al=%b tick=%b bcd=%h exp=1 1 071500", alarm, sec_tick, bcd_time); end
        repeat (8) cyc();
        n_tests++; if (alarm !== 1'b1 || bcd_time !== 24'h071502) begin n_fail++; $display("FAIL alarm_hold al=%b bcd=%h exp=1 071502", alarm, bcd_time); end
        alarm_ack = 1'b1; cyc(); alarm_ack = 1'b0;
        n_tests++; if (alarm !== 1'b0) begin n_fail++; $display("FAIL alarm_ack got=%b exp=0", alarm); end
        run = 1'b0;
        load(5'd7, 6'd15, 6'd0);
        cyc();
        n_tests++; if (alarm !== 1'b0) begin n_fail++; $display("FAIL alarm_on_load got=%b exp=0", alarm); end
        run = 1'b1;
        load(5'd7, 6'd14, 6'd59);
        repeat (4) cyc();
        n_tests++; if (alarm !== 1'b1) begin n_fail++; $display("FAIL alarm_rise2 got=%b exp=1", alarm); end
        alarm_en = 1'b0; cyc(); alarm_en = 1'b1;
        n_tests++; if (alarm !== 1'b0) begin n_fail++; $display("FAIL alarm_en_clear got=%b exp=0", alarm); end
        run = 1'b0;
    endtask

    task automatic test_pause();
        run = 1'b1;
        load(5'd2, 6'd0, 6'd0);
        cyc(); cyc();
        run = 1'b0;
        for (int i = 0; i < 10; i++) begin
            cyc();
            n_tests++; if (sec_tick !== 1'b0 || bcd_time !== 24'h020000) begin n_fail++; $display("FAIL pause cyc=%0d tick=%b bcd=%h exp=0 020000", i, sec_tick, bcd_time); end
        end
        run = 1'b1;
        cyc();
        n_tests++; if (sec_tick !== 1'b0) begin n_fail++; $display("FAIL resume_early got=%b exp=0", sec_tick); end
        cyc();
        n_tests++; if (sec_tick !== 1'b1 || bcd_time !== 24'h020001) begin n_fail++; $display("FAIL resume_tick tick=%b bcd=%h exp=1 020001", sec_tick, bcd_time); end
        run = 1'b0;
    endtask

    task automatic test_reset_mid();
        alarm_en = 1'b1; run = 1'b1;
        load(5'd7, 6'd14, 6'd59);
        repeat (5) cyc();
        n_tests++; if (alarm !== 1'b1) begin n_fail++; $display("FAIL rmid_pre_alarm got=%b exp=1", alarm); end
        reset = 1'b1; cyc(); reset = 1'b0;
        n_tests++; if (bcd_time !== 24'h000000 || alarm !== 1'b0 || sec_tick !== 1'b0) begin n_fail++; $display("FAIL rmid_clear bcd=%h al=%b tick=%b exp=000000 0 0", bcd_time, alarm, sec_tick); end
        for (int i = 0; i < 4; i++) begin
            cyc();
            n_tests++; if (sec_tick !== (i == 3)) begin n_fail++; $display("FAIL rmid_tick cyc=%0d got=%b exp=%b", i, sec_tick, i == 3); end
        end
        n_tests++; if (bcd_time !== 24'h000001) begin n_fail++; $display("FAIL rmid_bcd got=%h exp=000001", bcd_time); end
        run = 1'b0;
    endtask

    initial begin
        test_reset();
        test_rollover();
        test_mode_12h();
        test_set();
        test_alarm();
        test_pause();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
